// File: rtl/cla_pkg.sv
// Shared defaults and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

    // Default operand width in bits.
    localparam int CLA_DEF_WIDTH = 16;

    // Default lookahead group size in bits.
    localparam int CLA_DEF_GROUP = 4;

    // Number of lookahead groups that tile an operand.
    function automatic int cla_num_groups(input int width, input int group);
        return width / group;
    endfunction

endpackage

// File: rtl/cla_group.sv
// One carry-lookahead group: group propagate/generate and the group's sum bits.
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = CLA_DEF_GROUP
) (
    input  logic [GROUP-1:0] p,
    input  logic [GROUP-1:0] g,
    input  logic             cin,
    output logic             gp,
    output logic             gg,
    output logic [GROUP-1:0] s
);

    logic carry_s;

    // Group propagate and generate; deliberately independent of cin so the
    // inter-group lookahead never loops back through this block.
    always_comb begin
        gp = &p;
        gg = 1'b0;
        for (int k = 0; k < GROUP; k++) begin
            gg = g[k] | (p[k] & gg);
        end
    end

    // Sum bits of this group from the group carry-in.
    always_comb begin
        carry_s = cin;
        s       = '0;
        for (int k = 0; k < GROUP; k++) begin
            s[k]    = p[k] ^ carry_s;
            carry_s = g[k] | (p[k] & carry_s);
        end
    end

endmodule

// File: rtl/pipe_cla_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshakes.
// Stage 1 registers bit propagate/generate and cin; stage 2 resolves group
// carries by lookahead and registers sum/cout.
// Optional feature: define CLA_OVF_EN to add the registered signed-overflow
// output ovf.
module pipe_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_DEF_WIDTH,
    parameter int GROUP = CLA_DEF_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NG = cla_num_groups(WIDTH, GROUP);

    // Stage 1 state.
    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_p_r;
    logic [WIDTH-1:0] s1_g_r;
    logic             s1_cin_r;

    // Stage 2 (output) state.
    logic             out_valid_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    // Handshake and datapath nets.
    logic             s2_adv_s;
    logic             s1_adv_s;
    logic             accept_s;
    logic [NG-1:0]    grp_p_s;
    logic [NG-1:0]    grp_g_s;
    logic [NG:0]      grp_c_s;
    logic [WIDTH-1:0] sum_s;
    logic             cout_s;
    logic             term_s;
    logic             acc_s;

    // Pipeline advance: a stage moves when it is empty or its successor moves.
    // in_ready only looks at pipeline state and out_ready, never at in_valid.
    always_comb begin
        s2_adv_s = ~out_valid_r | out_ready;
        s1_adv_s = ~s1_valid_r | s2_adv_s;
        in_ready = s1_adv_s;
        accept_s = in_valid & s1_adv_s;
    end

    // Stage 1 register: capture bitwise propagate/generate and carry-in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_p_r     <= '0;
            s1_g_r     <= '0;
            s1_cin_r   <= 1'b0;
        end else if (s1_adv_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_p_r   <= a ^ b;
                s1_g_r   <= a & b;
                s1_cin_r <= cin;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_grp
            cla_group #(
                .GROUP (GROUP)
            ) u_grp (
                .p   (s1_p_r[gi*GROUP +: GROUP]),
                .g   (s1_g_r[gi*GROUP +: GROUP]),
                .cin (grp_c_s[gi]),
                .gp  (grp_p_s[gi]),
                .gg  (grp_g_s[gi]),
                .s   (sum_s[gi*GROUP +: GROUP])
            );
        end
    endgenerate

    // Group carries as flat sum-of-products over group P/G and the registered
    // cin, so no carry waits on the previous group's carry.
    always_comb begin
        grp_c_s    = '0;
        term_s     = 1'b0;
        acc_s      = 1'b0;
        grp_c_s[0] = s1_cin_r;
        for (int i = 0; i < NG; i++) begin
            acc_s = 1'b0;
            for (int j = 0; j <= i; j++) begin
                term_s = grp_g_s[j];
                for (int k = j + 1; k <= i; k++) begin
                    term_s = term_s & grp_p_s[k];
                end
                acc_s = acc_s | term_s;
            end
            term_s = s1_cin_r;
            for (int k = 0; k <= i; k++) begin
                term_s = term_s & grp_p_s[k];
            end
            grp_c_s[i+1] = acc_s | term_s;
        end
        cout_s = grp_c_s[NG];
    end

    // Stage 2 register: result and carry-out, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
        end else if (s2_adv_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                sum_r  <= sum_s;
                cout_r <= cout_s;
            end
        end
    end

`ifdef CLA_OVF_EN
    logic ovf_r;
    logic ovf_s;

    // Carry into the MSB is recovered as p[MSB] ^ sum[MSB]; overflow is that
    // carry disagreeing with cout.
    always_comb begin
        ovf_s = s1_p_r[WIDTH-1] ^ sum_s[WIDTH-1] ^ cout_s;
    end

    // Overflow register, aligned with sum_r/cout_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (s2_adv_s && s1_valid_r) begin
            ovf_r <= ovf_s;
        end
    end

    assign ovf = ovf_r;
`endif

    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Self-checking bench for pipe_cla_adder: a 16/4 instance for directed cases
// and a 32/8 instance for randomized traffic, both scoreboarded.
module tb_pipe_cla_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        iv16, ir16, ov16, or16, cin16, cout16;
    logic [15:0] a16, b16, sum16;
    logic        iv32, ir32, ov32, or32, cin32, cout32;
    logic [31:0] a32, b32, sum32;
`ifdef CLA_OVF_EN
    logic        ovf16, ovf32;
`endif

    pipe_cla_adder #(.WIDTH(16), .GROUP(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .cin(cin16), .out_valid(ov16), .out_ready(or16),
        .sum(sum16), .cout(cout16)
`ifdef CLA_OVF_EN
        , .ovf(ovf16)
`endif
    );

    pipe_cla_adder #(.WIDTH(32), .GROUP(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .a(a32), .b(b32), .cin(cin32), .out_valid(ov32), .out_ready(or32),
        .sum(sum32), .cout(cout32)
`ifdef CLA_OVF_EN
        , .ovf(ovf32)
`endif
    );

    int checks = 0;
    int errors = 0;
    int acc32  = 0;

    logic [17:0] q16[$];   // {ovf, cout, sum}
    logic [33:0] q32[$];   // {ovf, cout, sum}

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] m16(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] t;
        logic        v;
        t = {1'b0, x} + {1'b0, y} + {16'd0, c};
        v = (x[15] == y[15]) && (t[15] != x[15]);
        return {v, t};
    endfunction

    function automatic logic [33:0] m32(input logic [31:0] x, input logic [31:0] y, input logic c);
        logic [32:0] t;
        logic        v;
        t = {1'b0, x} + {1'b0, y} + {32'd0, c};
        v = (x[31] == y[31]) && (t[31] != x[31]);
        return {v, t};
    endfunction

    // Evaluate the handshakes that the next rising edge will see, then move
    // on to the following falling edge.
    task automatic tick();
        logic [17:0] e16;
        logic [33:0] e32;
        #1;
        if (iv16 && ir16) q16.push_back(m16(a16, b16, cin16));
        if (iv32 && ir32) begin
            q32.push_back(m32(a32, b32, cin32));
            acc32++;
        end
        if (ov16 && or16) begin
            if (q16.size() == 0) begin
                chk("pop16_qsize", 64'(q16.size()), 64'd1);
            end else begin
                e16 = q16.pop_front();
                chk("sum16", 64'(sum16), 64'(e16[15:0]));
                chk("cout16", 64'(cout16), 64'(e16[16]));
`ifdef CLA_OVF_EN
                chk("ovf16", 64'(ovf16), 64'(e16[17]));
`endif
            end
        end
        if (ov32 && or32) begin
            if (q32.size() == 0) begin
                chk("pop32_qsize", 64'(q32.size()), 64'd1);
            end else begin
                e32 = q32.pop_front();
                chk("sum32", 64'(sum32), 64'(e32[31:0]));
                chk("cout32", 64'(cout32), 64'(e32[32]));
`ifdef CLA_OVF_EN
                chk("ovf32", 64'(ovf32), 64'(e32[33]));
`endif
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((q16.size() != 0 || q32.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain16_left", 64'(q16.size()), 64'd0);
        chk("drain32_left", 64'(q32.size()), 64'd0);
    endtask

    // One isolated operation on the 16-bit instance with explicit latency
    // and result checks on top of the scoreboard.
    task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic c,
                        input logic [15:0] es, input logic ec, input logic eo);
        or16 = 1'b1;
        a16 = x; b16 = y; cin16 = c; iv16 = 1'b1;
        tick();
        iv16 = 1'b0;
        chk("lat_cycle1_valid", 64'(ov16), 64'd0);
        tick();
        chk("lat_cycle2_valid", 64'(ov16), 64'd1);
        chk("op_sum", 64'(sum16), 64'(es));
        chk("op_cout", 64'(cout16), 64'(ec));
`ifdef CLA_OVF_EN
        chk("op_ovf", 64'(ovf16), 64'(eo));
`else
        if (eo) begin end
`endif
        tick();
    endtask

    initial begin
        logic [15:0] held;
        int guard;
        rst_n = 1'b0;
        iv16 = 1'b0; a16 = 16'd0; b16 = 16'd0; cin16 = 1'b0; or16 = 1'b1;
        iv32 = 1'b0; a32 = 32'd0; b32 = 32'd0; cin32 = 1'b0; or32 = 1'b1;

        // Reset state before any clock edge.
        #2;
        chk("rst_out_valid16", 64'(ov16), 64'd0);
        chk("rst_sum16", 64'(sum16), 64'd0);
        chk("rst_cout16", 64'(cout16), 64'd0);
        chk("rst_out_valid32", 64'(ov32), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready16", 64'(ir16), 64'd1);
        chk("post_rst_in_ready32", 64'(ir32), 64'd1);

        // Directed single operations.
        op16(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        op16(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        op16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        op16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        op16(16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Back-to-back with a stalled consumer.
        or16 = 1'b0;
        a16 = 16'h0101; b16 = 16'h0202; cin16 = 1'b0; iv16 = 1'b1;
        tick();
        a16 = 16'h1000; b16 = 16'h2000; cin16 = 1'b1;
        tick();
        a16 = 16'hF00F; b16 = 16'h0FF1; cin16 = 1'b0;
        #1;
        chk("stall_in_ready", 64'(ir16), 64'd0);
        held = 16'h0303;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_out_valid", 64'(ov16), 64'd1);
            chk("stall_sum_held", 64'(sum16), 64'(held));
            chk("stall_in_ready_low", 64'(ir16), 64'd0);
        end
        or16 = 1'b1;
        #1;
        chk("resume_in_ready", 64'(ir16), 64'd1);
        tick();
        iv16 = 1'b0;
        drain(20);

        // Reset with two operations in flight.
        or16 = 1'b0;
        a16 = 16'h1111; b16 = 16'h1111; cin16 = 1'b0; iv16 = 1'b1;
        tick();
        a16 = 16'h2222; b16 = 16'h2222;
        tick();
        iv16 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(ov16), 64'd0);
        chk("midrst_sum", 64'(sum16), 64'd0);
        chk("midrst_cout", 64'(cout16), 64'd0);
`ifdef CLA_OVF_EN
        chk("midrst_ovf", 64'(ovf16), 64'd0);
`endif
        q16.delete();
        @(negedge clk);
        rst_n = 1'b1;
        or16 = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(ir16), 64'd1);
        tick();
        chk("no_stale_result", 64'(ov16), 64'd0);
        op16(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

        // Random traffic on the 32/8 instance with random back-pressure.
        guard = 0;
        while (acc32 < 1000 && guard < 20000) begin
            iv32  = ($urandom_range(0, 3) != 0);
            a32   = $urandom;
            b32   = $urandom;
            cin32 = 1'($urandom_range(0, 1));
            or32  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                a32 = 32'hFFFF_FFFF;
                b32 = 32'h0000_0000;
                cin32 = 1'b1;
            end
            tick();
            guard++;
        end
        iv32 = 1'b0;
        or32 = 1'b1;
        chk("rand_accepted", 64'(acc32), 64'd1000);
        drain(50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values are multiples of GROUP, 4..64.
REQ-002 SHALL have parameter GROUP, default 4, lookahead group size in bits; legal values are 2, 4 and 8.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  a/b/cin hold a valid operation.
REQ-006 SHALL have port in_ready  output  1  block accepts the operation this cycle.
REQ-007 SHALL have port a  input  WIDTH  first operand.
REQ-008 SHALL have port b  input  WIDTH  second operand.
REQ-009 SHALL have port cin  input  1  carry-in.
REQ-010 SHALL have port out_valid  output  1  sum/cout hold a valid result.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-012 SHALL have port sum  output  WIDTH  a+b+cin modulo 2^WIDTH.
REQ-013 SHALL have port cout  output  1  carry out of bit WIDTH-1.
REQ-014 SHALL have port ovf  output  1  signed overflow; present only under CLA_OVF_EN.

Function
REQ-015 SHALL accept an operation on every cycle where in_valid and in_ready are both 1, and on no other cycle.
REQ-016 SHALL, in stage 1, register cin plus bit propagate p=a^b and bit generate g=a&b for every bit.
REQ-017 SHALL, in stage 2, compute group P/G per GROUP, ripple-free carries across groups by lookahead from registered cin, then register sum and cout.
REQ-018 SHALL present the result with out_valid=1 exactly 2 cycles after acceptance when out_ready is held 1.
REQ-019 SHALL sustain one result per cycle with out_ready held 1.
REQ-020 SHALL advance stage 2 when it is empty or out_ready=1, and SHALL advance stage 1 when it is empty or stage 2 advances.
REQ-021 SHALL drive in_ready=1 when stage 1 is empty or stage 1 advances; in_ready SHALL NOT depend combinationally on in_valid.
REQ-022 SHALL hold sum, cout, ovf and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, when both stages are full and the output is stalled, hold in_ready=0 and keep all data; no operation is lost or duplicated.
REQ-024 SHALL give the wrap-around result with cout=1 for a=2^WIDTH-1, b=0, cin=1, i.e. sum=0.
REQ-025 SHALL, on a simultaneous pop at the output and push at the input, move both through in the same cycle.

Reset
REQ-026 SHALL, while rst_n=0, force out_valid=0, sum=0, cout=0, ovf=0 and both stage-valid flags to 0, independent of clk.
REQ-027 SHALL discard in-flight operations on reset mid-operation; the first result after release is the first operation accepted after release.
REQ-028 SHALL drive in_ready=1 in the first cycle after rst_n deasserts.

Configuration
REQ-029 SHALL, with macro CLA_OVF_EN defined, provide ovf = carry into MSB XOR cout, registered and aligned with sum.
REQ-030 SHALL, without CLA_OVF_EN, omit the ovf port and its logic; all other behaviour is identical.

Structure
REQ-031 SHALL take defaults for WIDTH and GROUP, and the group-count function WIDTH/GROUP, from shared package cla_pkg.
REQ-032 SHALL instantiate sub-module cla_group once per group; it computes group P, group G and GROUP sum bits from p, g and a carry-in.

Verification
REQ-033 SHALL cover: WIDTH=16, a=0x1234, b=0x4321, cin=0, out_ready=1 -> sum=0x5555, cout=0, out_valid 2 cycles later.
REQ-034 SHALL cover: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0.
REQ-035 SHALL cover: a=0x7FFF, b=0x0001, cin=0 with CLA_OVF_EN -> sum=0x8000, cout=0, ovf=1.
REQ-036 SHALL cover: 3 back-to-back operations, out_ready=0 for 4 cycles -> in_ready=0 after 2 accepted, output held, all 3 results in order once out_ready=1.
REQ-037 SHALL cover: rst_n pulsed low with 2 operations in flight -> out_valid=0 at once, no stale result after release.
REQ-038 SHALL cover: 1000 random operations at WIDTH=32, GROUP=8 with random out_ready -> every result equals the reference sum, in order.
